// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with same-cycle writeback forwarding
// and a per-register scoreboard of in-flight producers.
module regfile_sb #(
    parameter int AWidth  = 5,
    parameter int DWidth  = 32,
    parameter int NRead   = 2,
    parameter int ZeroReg = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRead*AWidth-1:0] ra,
    output logic [NRead*DWidth-1:0] rd,
    output logic [NRead-1:0]        rbusy,
    input  logic                    we0,
    input  logic [AWidth-1:0]       wa0,
    input  logic [DWidth-1:0]       wd0,
    input  logic                    we1,
    input  logic [AWidth-1:0]       wa1,
    input  logic [DWidth-1:0]       wd1,
    input  logic                    iss,
    input  logic [AWidth-1:0]       iss_wa,
    input  logic [AWidth-1:0]       dbg_ra,
    output logic [DWidth-1:0]       dbg_rd,
    output logic [AWidth:0]         busy_cnt
);

    localparam int NRegs = 1 << AWidth;
    localparam bit HasZero = (ZeroReg != 0);
    localparam logic [NRegs-1:0] OneHot0 = {{(NRegs-1){1'b0}}, 1'b1};

    logic [DWidth-1:0] mem_q [NRegs];
    logic [DWidth-1:0] mem_d [NRegs];
    logic [NRegs-1:0]  busy_q;
    logic [NRegs-1:0]  busy_d;

    logic [NRegs-1:0]  wr0_dec;
    logic [NRegs-1:0]  wr1_dec;
    logic [NRegs-1:0]  iss_dec;
    logic [NRegs-1:0]  keep_mask;
    logic [AWidth:0]   cnt;

    always_comb begin
        wr0_dec   = we0 ? (OneHot0 << wa0) : '0;
        wr1_dec   = we1 ? (OneHot0 << wa1) : '0;
        iss_dec   = iss ? (OneHot0 << iss_wa) : '0;
        keep_mask = HasZero ? ~OneHot0 : '1;
    end

    // Port 1 overrides port 0 on a shared target; issue overrides writeback clear.
    always_comb begin
        mem_d = mem_q;
        for (int r = 0; r < NRegs; r++) begin
            if (wr1_dec[r] && keep_mask[r]) begin
                mem_d[r] = wd1;
            end else if (wr0_dec[r] && keep_mask[r]) begin
                mem_d[r] = wd0;
            end
        end
        busy_d = ((busy_q & ~(wr0_dec | wr1_dec)) | iss_dec) & keep_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NRegs; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NRegs; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRead; k++) begin : g_read
        logic [AWidth-1:0] ra_k;
        logic [DWidth-1:0] rd_k;
        logic              hit0_k;
        logic              hit1_k;

        assign ra_k   = ra[k*AWidth +: AWidth];
        assign hit0_k = we0 && (wa0 == ra_k);
        assign hit1_k = we1 && (wa1 == ra_k);

        always_comb begin
            rd_k = mem_q[ra_k];
            if (hit0_k) begin
                rd_k = wd0;
            end
            if (hit1_k) begin
                rd_k = wd1;
            end
            if (HasZero && (ra_k == '0)) begin
                rd_k = '0;
            end
        end

        // A writeback in flight this cycle retires the producer the reader waits on.
        assign rd[k*DWidth +: DWidth] = rd_k;
        assign rbusy[k] = busy_q[ra_k] && !(hit0_k || hit1_k);
    end

    assign dbg_rd = (HasZero && (dbg_ra == '0)) ? '0 : mem_q[dbg_ra];

    always_comb begin
        cnt = '0;
        for (int r = 0; r < NRegs; r++) begin
            cnt = cnt + {{AWidth{1'b0}}, busy_q[r]};
        end
    end

    assign busy_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb across three parameter sets:
// default, a tiny file without a zero register, and a 4-port 16-bit file.
module tb_regfile_sb;

    logic clk;
    logic rst;

    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic        a_we0, a_we1, a_iss;
    logic [4:0]  a_wa0, a_wa1, a_iss_wa, a_dbg_ra;
    logic [31:0] a_wd0, a_wd1, a_dbg_rd;
    logic [5:0]  a_busy_cnt;

    logic [3:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rbusy;
    logic        b_we0, b_we1, b_iss;
    logic [1:0]  b_wa0, b_wa1, b_iss_wa, b_dbg_ra;
    logic [31:0] b_wd0, b_wd1, b_dbg_rd;
    logic [2:0]  b_busy_cnt;

    logic [19:0] c_ra;
    logic [63:0] c_rd;
    logic [3:0]  c_rbusy;
    logic        c_we0, c_we1, c_iss;
    logic [4:0]  c_wa0, c_wa1, c_iss_wa, c_dbg_ra;
    logic [15:0] c_wd0, c_wd1, c_dbg_rd;
    logic [5:0]  c_busy_cnt;

    logic [31:0] exp_q [$];
    logic [31:0] e;
    int          checks;
    int          errors;
    logic [15:0] c_ref [32];

    regfile_sb #(.AWidth(5), .DWidth(32), .NRead(2), .ZeroReg(1)) u_a (
        .clk(clk), .rst(rst), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy),
        .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
        .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
        .iss(a_iss), .iss_wa(a_iss_wa),
        .dbg_ra(a_dbg_ra), .dbg_rd(a_dbg_rd), .busy_cnt(a_busy_cnt)
    );

    regfile_sb #(.AWidth(2), .DWidth(32), .NRead(2), .ZeroReg(0)) u_b (
        .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
        .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .iss(b_iss), .iss_wa(b_iss_wa),
        .dbg_ra(b_dbg_ra), .dbg_rd(b_dbg_rd), .busy_cnt(b_busy_cnt)
    );

    regfile_sb #(.AWidth(5), .DWidth(16), .NRead(4), .ZeroReg(1)) u_c (
        .clk(clk), .rst(rst), .ra(c_ra), .rd(c_rd), .rbusy(c_rbusy),
        .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0),
        .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
        .iss(c_iss), .iss_wa(c_iss_wa),
        .dbg_ra(c_dbg_ra), .dbg_rd(c_dbg_rd), .busy_cnt(c_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_we0 = 1'b1; a_wa0 = 5'd6; a_wd0 = 32'hDEAD;
        a_ra = {5'd5, 5'd5};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL reset_rd0 actual=%h required=%h", a_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL reset_cnt actual=%0d required=%0d", a_busy_cnt, e); end

        tick();
        rst = 1'b0;
        a_wa0 = 5'd5; a_wd0 = 32'h1234;
        exp_q.push_back(32'h1234);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL write_bypass_r5 actual=%h required=%h", a_rd[31:0], e); end

        tick();
        a_we0 = 1'b0; a_iss = 1'b1; a_iss_wa = 5'd5; a_dbg_ra = 5'd5;
        exp_q.push_back(32'h1234);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_dbg_rd !== e) begin errors++; $display("FAIL dbg_r5 actual=%h required=%h", a_dbg_rd, e); end

        tick();
        a_iss = 1'b0; a_dbg_ra = 5'd6;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_dbg_rd !== e) begin errors++; $display("FAIL write_in_reset_ignored actual=%h required=%h", a_dbg_rd, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL cnt_before_reset actual=%0d required=%0d", a_busy_cnt, e); end

        #1;
        rst = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL async_reset_rd0 actual=%h required=%h", a_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL async_reset_cnt actual=%0d required=%0d", a_busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_rbusy[0]) !== e) begin errors++; $display("FAIL async_reset_rbusy actual=%0d required=%0d", a_rbusy[0], e); end

        tick();
        tick();
        rst = 1'b0;
        a_we0 = 1'b1; a_wa0 = 5'd0; a_wd0 = 32'hFFFFFFFF;
        a_iss = 1'b1; a_iss_wa = 5'd0;
        a_ra = {5'd5, 5'd0};
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL zero_reg_read actual=%h required=%h", a_rd[31:0], e); end

        tick();
        a_we0 = 1'b0; a_iss = 1'b0; a_dbg_ra = 5'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_dbg_rd !== e) begin errors++; $display("FAIL zero_reg_dbg actual=%h required=%h", a_dbg_rd, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL zero_reg_never_busy actual=%0d required=%0d", a_busy_cnt, e); end
    endtask

    task automatic test_bypass();
        tick();
        a_we0 = 1'b1; a_wa0 = 5'd7; a_wd0 = 32'hAAAA0000;
        a_we1 = 1'b1; a_wa1 = 5'd7; a_wd1 = 32'h5555FFFF;
        a_ra = {5'd7, 5'd7}; a_dbg_ra = 5'd7;
        exp_q.push_back(32'h5555FFFF);
        exp_q.push_back(32'h5555FFFF);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL dual_write_rd0 actual=%h required=%h", a_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (a_rd[63:32] !== e) begin errors++; $display("FAIL dual_write_rd1 actual=%h required=%h", a_rd[63:32], e); end
        e = exp_q.pop_front(); checks++;
        if (a_dbg_rd !== e) begin errors++; $display("FAIL dbg_no_bypass actual=%h required=%h", a_dbg_rd, e); end

        tick();
        a_we1 = 1'b0;
        a_wa0 = 5'd8; a_wd0 = 32'h11;
        a_ra = {5'd7, 5'd8};
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h5555FFFF);
        exp_q.push_back(32'h5555FFFF);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL port0_bypass actual=%h required=%h", a_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (a_rd[63:32] !== e) begin errors++; $display("FAIL stored_r7_rd1 actual=%h required=%h", a_rd[63:32], e); end
        e = exp_q.pop_front(); checks++;
        if (a_dbg_rd !== e) begin errors++; $display("FAIL dbg_r7_after actual=%h required=%h", a_dbg_rd, e); end
        tick();
        a_we0 = 1'b0;
    endtask

    task automatic test_scoreboard();
        a_iss = 1'b1; a_iss_wa = 5'd3; a_ra = {5'd0, 5'd3};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (32'(a_rbusy[0]) !== e) begin errors++; $display("FAIL iss_not_visible actual=%0d required=%0d", a_rbusy[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL cnt_before_iss actual=%0d required=%0d", a_busy_cnt, e); end

        tick();
        a_iss = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h1);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (32'(a_rbusy[0]) !== e) begin errors++; $display("FAIL busy_cycle%0d actual=%0d required=%0d", i, a_rbusy[0], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL cnt_cycle%0d actual=%0d required=%0d", i, a_busy_cnt, e); end
            tick();
        end

        a_we1 = 1'b1; a_wa1 = 5'd3; a_wd1 = 32'h42;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h42);
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (32'(a_rbusy[0]) !== e) begin errors++; $display("FAIL wb_unbusy actual=%0d required=%0d", a_rbusy[0], e); end
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL wb_forward actual=%h required=%h", a_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL cnt_in_wb actual=%0d required=%0d", a_busy_cnt, e); end

        tick();
        a_we1 = 1'b0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL cnt_after_wb actual=%0d required=%0d", a_busy_cnt, e); end
    endtask

    task automatic test_set_beats_clear();
        tick();
        a_iss = 1'b1; a_iss_wa = 5'd9;
        tick();
        a_we0 = 1'b1; a_wa0 = 5'd9; a_wd0 = 32'h99;
        a_ra = {5'd0, 5'd9}; a_dbg_ra = 5'd9;
        exp_q.push_back(32'h99);
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== e) begin errors++; $display("FAIL sbc_forward actual=%h required=%h", a_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL sbc_cnt_during actual=%0d required=%0d", a_busy_cnt, e); end

        tick();
        a_we0 = 1'b0; a_iss = 1'b0;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h99);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (32'(a_rbusy[0]) !== e) begin errors++; $display("FAIL sbc_still_busy actual=%0d required=%0d", a_rbusy[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(a_busy_cnt) !== e) begin errors++; $display("FAIL sbc_cnt_after actual=%0d required=%0d", a_busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (a_dbg_rd !== e) begin errors++; $display("FAIL sbc_stored actual=%h required=%h", a_dbg_rd, e); end
    endtask

    task automatic test_full_scoreboard();
        tick();
        b_iss = 1'b1;
        for (int r = 0; r < 4; r++) begin
            b_iss_wa = 2'(r);
            tick();
        end
        b_iss = 1'b0; b_ra = {2'd1, 2'd0};
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (32'(b_busy_cnt) !== e) begin errors++; $display("FAIL full_cnt actual=%0d required=%0d", b_busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(b_rbusy[0]) !== e) begin errors++; $display("FAIL r0_busy_nozero actual=%0d required=%0d", b_rbusy[0], e); end

        tick();
        b_we0 = 1'b1; b_wa0 = 2'd2; b_wd0 = 32'h77; b_ra = {2'd1, 2'd2};
        exp_q.push_back(32'h77);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (b_rd[31:0] !== e) begin errors++; $display("FAIL full_wb_forward actual=%h required=%h", b_rd[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(b_rbusy[0]) !== e) begin errors++; $display("FAIL full_wb_unbusy actual=%0d required=%0d", b_rbusy[0], e); end

        tick();
        b_we0 = 1'b0;
        exp_q.push_back(32'h3);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (32'(b_busy_cnt) !== e) begin errors++; $display("FAIL full_cnt_after actual=%0d required=%0d", b_busy_cnt, e); end
    endtask

    task automatic test_param_sweep();
        int          addr [4];
        logic [4:0]  rk;
        logic [15:0] ev;
        addr = '{0, 4, 17, 31};
        for (int r = 0; r < 32; r++) c_ref[r] = 16'h0;
        tick();
        for (int cyc = 0; cyc < 24; cyc++) begin
            c_we0 = 1'($urandom_range(0, 1));
            c_we1 = 1'($urandom_range(0, 1));
            c_wa0 = 5'(addr[$urandom_range(0, 3)]);
            c_wa1 = 5'(addr[$urandom_range(0, 3)]);
            c_wd0 = 16'($urandom);
            c_wd1 = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                rk = 5'(addr[(k + cyc) % 4]);
                c_ra[k*5 +: 5] = rk;
                if (rk == 5'd0) ev = 16'h0;
                else if (c_we1 && c_wa1 == rk) ev = c_wd1;
                else if (c_we0 && c_wa0 == rk) ev = c_wd0;
                else ev = c_ref[rk];
                exp_q.push_back(32'(ev));
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); checks++;
                if (32'(c_rd[k*16 +: 16]) !== e) begin
                    errors++;
                    $display("FAIL sweep_c%0d_p%0d actual=%h required=%h", cyc, k, c_rd[k*16 +: 16], e[15:0]);
                end
            end
            if (c_we0 && c_wa0 != 5'd0) c_ref[c_wa0] = c_wd0;
            if (c_we1 && c_wa1 != 5'd0) c_ref[c_wa1] = c_wd1;
            tick();
        end
        c_we0 = 1'b0; c_we1 = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        a_ra = '0; a_we0 = 1'b0; a_wa0 = '0; a_wd0 = '0; a_we1 = 1'b0; a_wa1 = '0; a_wd1 = '0;
        a_iss = 1'b0; a_iss_wa = '0; a_dbg_ra = '0;
        b_ra = '0; b_we0 = 1'b0; b_wa0 = '0; b_wd0 = '0; b_we1 = 1'b0; b_wa1 = '0; b_wd1 = '0;
        b_iss = 1'b0; b_iss_wa = '0; b_dbg_ra = '0;
        c_ra = '0; c_we0 = 1'b0; c_wa0 = '0; c_wd0 = '0; c_we1 = 1'b0; c_wa1 = '0; c_wd1 = '0;
        c_iss = 1'b0; c_iss_wa = '0; c_dbg_ra = '0;
        $display("[TB] regfile_sb bench start");
        test_reset();
        test_bypass();
        test_scoreboard();
        test_set_beats_clear();
        test_full_scoreboard();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read, dual-write register file with an integrated scoreboard for the pipelined CPU datapath. It holds the architectural registers, forwards same-cycle writebacks to every read port, and tracks which registers have an in-flight producer. Issue logic can stall on read-after-write hazards. It sits between decode (read/issue) and the two writeback paths: ALU on port 0, memory load on port 1.

## Interface
- AWidth, 5, register address width; 2^AWidth registers
- DWidth, 32, register data width
- NRead, 2, number of read ports (1..4)
- ZeroReg, 1, when 1, register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ra  in  NRead*AWidth  read addresses; port k in bits [k*AWidth +: AWidth]
- rd  out  NRead*DWidth  read data, same packing
- rbusy  out  NRead  busy flag of the register addressed by each read port
- we0, wa0, wd0  in  1 / AWidth / DWidth  write port 0 (ALU writeback)
- we1, wa1, wd1  in  1 / AWidth / DWidth  write port 1 (load writeback)
- iss  in  1  issue strobe; marks iss_wa busy
- iss_wa  in  AWidth  destination register of the issuing instruction
- dbg_ra  in  AWidth  debug read address (no bypass)
- dbg_rd  out  DWidth  debug read data, raw array contents
- busy_cnt  out  AWidth+1  number of registers currently busy

## Operation
- Storage: 2^AWidth x DWidth data array plus a 2^AWidth-bit busy vector.
- Write: on a rising edge, register r takes wd0 if we0 && wa0==r, and wd1 if we1 && wa1==r.
  - If both ports target the same r, port 1 wins.
  - With ZeroReg=1, writes to r=0 are dropped.
- Read port k is combinational. Priority:
  - (1) ZeroReg && ra_k==0 gives 0.
  - (2) we1 && wa1==ra_k gives wd1.
  - (3) we0 && wa0==ra_k gives wd0.
  - (4) otherwise the array value.
- dbg_rd returns the array value only, with no forwarding. With ZeroReg=1, dbg_ra=0 returns 0.
- Scoreboard update per edge, for each register r:
  - Clear if (we0 && wa0==r) || (we1 && wa1==r).
  - Set if iss && iss_wa==r; a set wins over a clear in the same cycle.
  - With ZeroReg=1, register 0 never sets.
- Issue to an already-busy register: the bit stays 1. The scoreboard tracks one outstanding producer per register; the issue stage guarantees this.
- rbusy_k = busy[ra_k] && no write to ra_k this cycle. Same-cycle writeback un-busies the read, consistent with the forwarded data.
- rbusy_k ignores a same-cycle iss to ra_k: the new producer is not yet visible.
- busy_cnt = popcount of the busy vector (registered state, combinational count).

## Timing
- Reset (asynchronous, immediate on rst=1): all registers 0, busy vector 0, busy_cnt 0.
  - rd and dbg_rd read 0 unless a write port forwards.
  - rbusy = 0.
- While rst=1, writes and issues are ignored. The first update occurs on the first rising edge after rst falls.
- Write latency: a write is visible on rd in the same cycle (bypass). It is visible on dbg_rd the cycle after the edge.
- Issue latency: a register issued at edge t shows rbusy=1 from just after edge t. busy_cnt increments after the same edge.
- Clear latency: rbusy drops combinationally in the writeback cycle. The busy bit and busy_cnt drop after that edge.
- Simultaneous events on the same register in one cycle:
  - Both write ports: port 1 data stored and forwarded.
  - Write and issue: data stored, register remains busy.
  - Write and read: forwarded value returned.
- busy_cnt range 0..2^AWidth; width AWidth+1 so a fully busy file does not wrap.
- No combinational path from iss to any output.

## Test plan
- Reset and zero register:
  - Stimulus: assert rst mid-run after writing r5=0x1234, then release; then we0=1, wa0=0, wd0=0xFFFFFFFF.
  - Required: rd for ra=5 reads 0 immediately on rst; after the write, ra=0 reads 0, dbg_rd[0]=0, busy_cnt=0.
- Bypass and priority:
  - Stimulus: in one cycle we0=1, wa0=7, wd0=0xAAAA0000 and we1=1, wa1=7, wd1=0x5555FFFF; read ra0=ra1=7.
  - Required: both rd ports read 0x5555FFFF in that cycle; next cycle dbg_rd[7]=0x5555FFFF.
- Scoreboard lifecycle:
  - Stimulus: iss with iss_wa=3; after 2 cycles, we1 to r3 with wd1=0x42; read ra0=3 throughout.
  - Required: rbusy0=1 for 2 cycles, 0 in the writeback cycle with rd0=0x42; busy_cnt goes 0→1→0.
- Set beats clear:
  - Stimulus: r9 busy; in one cycle we0 to r9 and iss with iss_wa=9.
  - Required: r9 written, rbusy=1 next cycle, busy_cnt unchanged.
- Full scoreboard:
  - Stimulus: with ZeroReg=0, AWidth=2, issue r0..r3 on consecutive cycles.
  - Required: busy_cnt=4, no wrap; after one we0 to r2, busy_cnt=3.
- Parameter sweep:
  - Stimulus: NRead=4, DWidth=16; four distinct addresses with random writes.
  - Required: each rd matches the reference model every cycle.
